// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and store lane helpers for the load/store controller
package lsu_pkg;
   localparam logic [1:0] LSU_BYTE = 2'd0;
   localparam logic [1:0] LSU_HALF = 2'd1;
   localparam logic [1:0] LSU_WORD = 2'd2;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RDATA, ST_RESP} lsu_state_e;

   function automatic logic [3:0] lsu_be(input logic [1:0] size, input logic [1:0] off);
      return size == LSU_BYTE ? 4'b0001 << off : size == LSU_HALF ? 4'b0011 << off : 4'b1111;
   endfunction

   function automatic logic [31:0] lsu_wdata(input logic [1:0] size, input logic [31:0] data);
      return size == LSU_BYTE ? {4{data[7:0]}} : size == LSU_HALF ? {2{data[15:0]}} : data;
   endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: right-aligns the addressed load lane and sign/zero-extends it
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);
   logic [31:0] lane;
   assign lane = rdata_i >> {offset_i, 3'b000};
   always_comb
      data_o = size_i == LSU_BYTE ? {{24{~unsigned_i & lane[7]}}, lane[7:0]} :
               size_i == LSU_HALF ? {{16{~unsigned_i & lane[15]}}, lane[15:0]} : lane;
endmodule

// File: rtl/lsu_ram_ctrl.sv
// lsu_ram_ctrl: single-outstanding load/store controller in front of a byte-write RAM
module lsu_ram_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [31:0]           req_addr_i,
   input  logic [31:0]           req_wdata_i,
   output logic                  rsp_valid_o,
   output logic                  rsp_err_o,
   output logic [31:0]           rsp_rdata_o,
   output logic [3:0]            ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [31:0]           ram_wdata_o,
   input  logic [31:0]           ram_rdata_i
);
   lsu_state_e            state_q, state_d;
   logic [1:0]            off_q, off_d, size_q, size_d;
   logic                  uns_q, uns_d, we_q, we_d;
   logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d, ram_wdata_q, ram_wdata_d;
   logic [3:0]            ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic                  req_err;
   logic [31:0]           load_data;

   assign req_err = req_size_i == 2'd3 || (req_size_i == LSU_HALF && req_addr_i[0]) ||
                    (req_size_i == LSU_WORD && req_addr_i[1:0] != 2'd0) || |req_addr_i[31:ADDR_WIDTH+2];

   lsu_load_align u_align (
      .rdata_i   (ram_rdata_i),
      .offset_i  (off_q),
      .size_i    (size_q),
      .unsigned_i(uns_q),
      .data_o    (load_data)
   );

   always_comb begin
      state_d = state_q;
      off_d = off_q;
      size_d = size_q;
      uns_d = uns_q;
      we_d = we_q;
      rsp_err_d = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      ram_we_d = '0;
      ram_addr_d = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      case (state_q)
         ST_IDLE: if (req_valid_i) begin
            off_d = req_addr_i[1:0];
            size_d = req_size_i;
            uns_d = req_unsigned_i;
            we_d = req_we_i;
            rsp_err_d = req_err;
            rsp_rdata_d = '0;
            state_d = req_err ? ST_RESP : ST_ACCESS;
            if (!req_err) begin
               ram_addr_d = req_addr_i[ADDR_WIDTH+1:2];
               ram_we_d = req_we_i ? lsu_be(req_size_i, req_addr_i[1:0]) : 4'b0000;
               ram_wdata_d = req_we_i ? lsu_wdata(req_size_i, req_wdata_i) : ram_wdata_q;
            end
         end
         ST_ACCESS: state_d = we_q ? ST_RESP : ST_RDATA;
         ST_RDATA: begin
            rsp_rdata_d = load_data;
            state_d = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase
      rsp_valid_d = state_d == ST_RESP;
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         off_q <= '0;
         size_q <= '0;
         uns_q <= 1'b0;
         we_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q <= 1'b0;
         rsp_rdata_q <= '0;
         ram_we_q <= '0;
         ram_addr_q <= '0;
         ram_wdata_q <= '0;
      end else begin
         state_q <= state_d;
         off_q <= off_d;
         size_q <= size_d;
         uns_q <= uns_d;
         we_q <= we_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         ram_we_q <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   assign req_ready_o = state_q == ST_IDLE;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o = rsp_err_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign ram_we_o = ram_we_q;
   assign ram_addr_o = ram_addr_q;
   assign ram_wdata_o = ram_wdata_q;
endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// tb_lsu_ram_ctrl: directed vector bench with a behavioural byte-write RAM
module tb_lsu_ram_ctrl;
   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = '0;
   logic        req_unsigned_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic        rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic [3:0]  ram_we_o;
   logic [9:0]  ram_addr_o;
   logic [31:0] ram_wdata_o;
   logic [31:0] ram_rdata_i = '0;
   logic [31:0] mem [1024];
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      int          lat;
      logic [3:0]  be;
      logic [31:0] ewd;
      logic [31:0] rdata;
   } vec_t;
   vec_t vecs[21];

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      for (int b = 0; b < 4; b++)
         if (ram_we_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      ram_rdata_i <= mem[ram_addr_o];
   end

   lsu_ram_ctrl #(.ADDR_WIDTH(10)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o),
      .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o), .ram_we_o(ram_we_o),
      .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_req(input int idx, input vec_t v);
      int n = 0;
      int lat;
      logic [3:0] we_seen;
      @(negedge clk_i);
      while (!req_ready_o && n < 10) begin
         @(negedge clk_i);
         n++;
      end
      req_we_i = v.we;
      req_size_i = v.size;
      req_unsigned_i = v.uns;
      req_addr_i = v.addr;
      req_wdata_i = v.wdata;
      req_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      lat = 1;
      we_seen = ram_we_o;
      if (v.be != 4'b0000) begin
         chk($sformatf("v%0d_ram_addr", idx), {22'b0, ram_addr_o}, {22'b0, v.addr[11:2]});
         chk($sformatf("v%0d_ram_wdata", idx), ram_wdata_o, v.ewd);
      end
      while (!rsp_valid_o && lat < 8) begin
         @(posedge clk_i);
         #1;
         lat++;
         we_seen |= ram_we_o;
      end
      chk($sformatf("v%0d_latency", idx), lat, v.lat);
      chk($sformatf("v%0d_err", idx), {31'b0, rsp_err_o}, {31'b0, v.err});
      chk($sformatf("v%0d_rdata", idx), rsp_rdata_o, v.rdata);
      chk($sformatf("v%0d_we", idx), {28'b0, we_seen}, {28'b0, v.be});
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d_pulse", idx), {31'b0, rsp_valid_o}, 32'd0);
   endtask

   initial begin
      int k;
      int prev;
      int busy;
      vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 2, 4'b1111, 32'hDEADBEEF, 32'h0};
      vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, 3, 4'b0000, 32'h0, 32'hFFFFFFDE};
      vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, 3, 4'b0000, 32'h0, 32'h000000DE};
      vecs[3]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'hABCD1234, 1'b0, 2, 4'b1100, 32'h12341234, 32'h0};
      vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 3, 4'b0000, 32'h0, 32'h1234BEEF};
      vecs[5]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h00008000, 1'b0, 2, 4'b1100, 32'h80008000, 32'h0};
      vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0, 3, 4'b0000, 32'h0, 32'hFFFF8000};
      vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0, 3, 4'b0000, 32'h0, 32'h00008000};
      vecs[8]  = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b0, 3, 4'b0000, 32'h0, 32'hFFFFFFEF};
      vecs[9]  = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b0, 3, 4'b0000, 32'h0, 32'h000000BE};
      vecs[10] = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h00000077, 1'b0, 2, 4'b0010, 32'h77777777, 32'h0};
      vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b0, 3, 4'b0000, 32'h0, 32'h000077EF};
      vecs[12] = '{1'b1, 2'd1, 1'b0, 32'h11, 32'h0000AAAA, 1'b1, 1, 4'b0000, 32'h0, 32'h0};
      vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 1'b1, 1, 4'b0000, 32'h0, 32'h0};
      vecs[14] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b1, 1, 4'b0000, 32'h0, 32'h0};
      vecs[15] = '{1'b1, 2'd2, 1'b0, 32'h1000, 32'h55555555, 1'b1, 1, 4'b0000, 32'h0, 32'h0};
      vecs[16] = '{1'b0, 2'd0, 1'b0, 32'h80000010, 32'h0, 1'b1, 1, 4'b0000, 32'h0, 32'h0};
      vecs[17] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 3, 4'b0000, 32'h0, 32'h800077EF};
      vecs[18] = '{1'b1, 2'd2, 1'b0, 32'hFFC, 32'hCAFEF00D, 1'b0, 2, 4'b1111, 32'hCAFEF00D, 32'h0};
      vecs[19] = '{1'b0, 2'd0, 1'b0, 32'hFFF, 32'h0, 1'b0, 3, 4'b0000, 32'h0, 32'hFFFFFFCA};
      vecs[20] = '{1'b0, 2'd1, 1'b1, 32'hFFE, 32'h0, 1'b0, 3, 4'b0000, 32'h0, 32'h0000CAFE};

      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_valid", {31'b0, rsp_valid_o}, 32'd0);
      chk("rst_err", {31'b0, rsp_err_o}, 32'd0);
      chk("rst_rdata", rsp_rdata_o, 32'd0);
      chk("rst_we", {28'b0, ram_we_o}, 32'd0);
      chk("rst_addr", {22'b0, ram_addr_o}, 32'd0);
      chk("rst_wdata", ram_wdata_o, 32'd0);
      rstn_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("rst_ready", {31'b0, req_ready_o}, 32'd1);

      for (int i = 0; i < 21; i++) do_req(i, vecs[i]);

      // three stores with valid held high: one accept every third cycle
      k = 0;
      prev = -1;
      busy = 0;
      @(negedge clk_i);
      req_we_i = 1'b1;
      req_size_i = 2'd2;
      req_addr_i = 32'h20;
      req_wdata_i = 32'h11111111;
      req_valid_i = 1'b1;
      for (int c = 0; c < 15 && k < 3; c++) begin
         if (c > 0) @(negedge clk_i);
         if (req_ready_o) begin
            if (k > 0) chk($sformatf("b2b_gap%0d", k), c - prev, 3);
            prev = c;
            @(posedge clk_i);
            #1;
            k++;
            req_addr_i = 32'h20 + 4 * k;
            req_wdata_i = 32'h11111111 * (k + 1);
            if (k == 3) req_valid_i = 1'b0;
         end else busy++;
      end
      req_valid_i = 1'b0;
      chk("b2b_accepts", k, 3);
      chk("b2b_busy", busy, 4);
      repeat (3) @(posedge clk_i);
      #1;
      chk("b2b_mem0", mem[8], 32'h11111111);
      chk("b2b_mem1", mem[9], 32'h22222222);
      chk("b2b_mem2", mem[10], 32'h33333333);

      // reset while a load sits in RDATA
      @(negedge clk_i);
      req_we_i = 1'b0;
      req_size_i = 2'd2;
      req_addr_i = 32'h10;
      req_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      rstn_i = 1'b0;
      @(posedge clk_i);
      #1;
      chk("mid_valid", {31'b0, rsp_valid_o}, 32'd0);
      chk("mid_err", {31'b0, rsp_err_o}, 32'd0);
      chk("mid_rdata", rsp_rdata_o, 32'd0);
      chk("mid_we", {28'b0, ram_we_o}, 32'd0);
      chk("mid_addr", {22'b0, ram_addr_o}, 32'd0);
      chk("mid_wdata", ram_wdata_o, 32'd0);
      req_we_i = 1'b1;
      req_addr_i = 32'h40;
      req_wdata_i = 32'h99999999;
      req_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("rstreq_we", {28'b0, ram_we_o}, 32'd0);
      chk("rstreq_addr", {22'b0, ram_addr_o}, 32'd0);
      chk("rstreq_valid", {31'b0, rsp_valid_o}, 32'd0);
      req_valid_i = 1'b0;
      rstn_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("rel_ready", {31'b0, req_ready_o}, 32'd1);
      chk("rel_valid", {31'b0, rsp_valid_o}, 32'd0);
      chk("rstreq_mem", mem[16], 32'h0);
      do_req(100, vecs[17]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
